// File: rtl/tff_pkg.sv
// ---------------------------------------------------------------------------
// tff_pkg
// Shared definitions for the T flip-flop counter slice.
//   state_t     : controller states (IDLE, RUN, DONE)
//   next_count  : next value of a modulo-M up/down count
//   is_wrap     : whether the current value is the wrap point of a count
// Both helpers work on MAX_W-bit zero-extended values so that one package
// serves every counter width up to MAX_W. Callers pass "last" = M-1 already
// reduced to their own width, which makes M = 0 (full range) come out as
// all ones and so wrap naturally.
// ---------------------------------------------------------------------------
package tff_pkg;

    localparam int MAX_W = 32;

    localparam logic [MAX_W-1:0] ONE_EXT = MAX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [MAX_W-1:0] next_count(
        input logic [MAX_W-1:0] cur,
        input logic             up,
        input logic [MAX_W-1:0] last
    );
        logic [MAX_W-1:0] nxt;
        if (up) begin
            nxt = (cur == last) ? '0 : cur + ONE_EXT;
        end else begin
            nxt = (cur == '0) ? last : cur - ONE_EXT;
        end
        return nxt;
    endfunction

    function automatic logic is_wrap(
        input logic [MAX_W-1:0] cur,
        input logic             up,
        input logic [MAX_W-1:0] last
    );
        return up ? (cur == last) : (cur == '0);
    endfunction

endpackage

// File: rtl/tff_bank.sv
// ---------------------------------------------------------------------------
// tff_bank
// A bank of WIDTH independent T flip-flops with synchronous active-high reset.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every bit
//   t    : per-bit toggle enables
//   q    : flip-flop outputs
//   qn   : complement of q
// ---------------------------------------------------------------------------
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Each bit flips where its toggle enable is set and holds otherwise.
    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// ---------------------------------------------------------------------------
// tff_count_ctrl
// Drives a tff_bank as a programmable modulo-M up/down counter with
// start/stop control, one-shot or free-running mode and registered
// terminal-count / done pulses. The count itself lives only in the bank;
// the controller works out the next value and toggles exactly the bits
// that differ (t = q ^ q_next).
// Parameters:
//   WIDTH   : counter width, 2 .. tff_pkg::MAX_W
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : begin a run (looked at only in IDLE)
//   stop    : abort a run (looked at only in RUN)
//   up      : direction, 1 = up, captured at start
//   oneshot : 1 = finish after the first wrap, captured at start
//   mod_val : modulus M, captured at start, 0 means 2^WIDTH
//   q, qn   : current count and its complement
//   busy    : high while in RUN
//   tc      : one-cycle pulse in the cycle showing the wrapped value
//   done    : one-cycle pulse marking the end of a one-shot run
// ---------------------------------------------------------------------------
module tff_count_ctrl
    import tff_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             up,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t           state_q, state_d;
    logic             up_q, up_d;
    logic             oneshot_q, oneshot_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] last_run;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] q_next;
    logic [MAX_W-1:0] q_ext;
    logic [MAX_W-1:0] last_ext;
    logic [MAX_W-1:0] next_ext;
    logic             wrap;
    logic             stepping;
    logic             unused_next_hi;

    tff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .t   (t),
        .q   (q),
        .qn  (qn)
    );

    // M-1 in WIDTH bits: M = 0 underflows to all ones, which is exactly the
    // last value of a full-range count, so no special case is needed.
    assign last_run = mod_q - WIDTH'(1);
    assign init_val = up ? '0 : (mod_val - WIDTH'(1));

    // Zero-extend into the package's working width and evaluate the step.
    always_comb begin
        q_ext                 = '0;
        last_ext              = '0;
        q_ext[WIDTH-1:0]      = q;
        last_ext[WIDTH-1:0]   = last_run;
        next_ext              = next_count(q_ext, up_q, last_ext);
        wrap                  = is_wrap(q_ext, up_q, last_ext);
    end

    assign q_next         = next_ext[WIDTH-1:0];
    assign unused_next_hi = ^next_ext;

    // A RUN cycle only counts when stop is low; stop overrides a wrap.
    assign stepping = (state_q == RUN) && !stop;

    // State register together with the capture and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            up_q      <= 1'b0;
            oneshot_q <= 1'b0;
            mod_q     <= '0;
            tc_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            up_q      <= up_d;
            oneshot_q <= oneshot_d;
            mod_q     <= mod_d;
            tc_q      <= tc_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (wrap && oneshot_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: toggle drive, pulse preparation and run-parameter capture.
    // The pulses are prepared on the wrap cycle and registered so they line
    // up with the cycle that shows the wrapped value.
    always_comb begin
        t         = '0;
        tc_d      = 1'b0;
        done_d    = 1'b0;
        up_d      = up_q;
        oneshot_d = oneshot_q;
        mod_d     = mod_q;
        if (state_q == IDLE && start) begin
            t         = q ^ init_val;
            up_d      = up;
            oneshot_d = oneshot;
            mod_d     = mod_val;
        end else if (stepping) begin
            t      = q ^ q_next;
            tc_d   = wrap;
            done_d = wrap && oneshot_q;
        end
    end

    assign busy = (state_q == RUN);
    assign tc   = tc_q;
    assign done = done_q;

endmodule
